// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int          MAX_PAT_W   = 64;
  localparam logic [15:0] SEQ_DEF_PAT = 16'b0000_0000_0011_0100;
  localparam int          SEQ_DEF_LEN = 6;
  localparam logic        SEQ_DEF_OVL = 1'b1;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Ones in the low len positions; the comparator ignores history above the pattern length.
  function automatic logic [MAX_PAT_W-1:0] len_mask(input int unsigned len);
    logic [MAX_PAT_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear and a sticky saturation flag.
module seq_match_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  // Clear has priority over increment; a match arriving at all-ones only sets the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_inc) begin
      if (&r_cnt) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap control and match counting.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int               PAT_W   = 16,
  parameter  int               CNT_W   = 8,
  parameter  logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT),
  parameter  int               DEF_LEN = SEQ_DEF_LEN,
  parameter  logic             DEF_OVL = SEQ_DEF_OVL,
  localparam int               LEN_W   = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             seq_found,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0]     r_pat;
  logic [PAT_W-1:0]     r_hist;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_fill;
  logic                 r_ovl;
  logic                 r_found;

  logic [PAT_W-1:0]     w_hist_next;
  logic [LEN_W-1:0]     w_fill_next;
  logic [LEN_W-1:0]     w_len_clamped;
  logic [MAX_PAT_W-1:0] w_mask;
  logic [MAX_PAT_W-1:0] w_diff;
  logic                 w_accept;
  logic                 w_match;

  // A load cycle swallows any data bit so the new pattern starts from empty history.
  always_comb begin
    w_accept    = data_valid & ~cfg_load;
    w_hist_next = {r_hist[PAT_W-2:0], data_in};
    if (r_fill == LEN_MAX) begin
      w_fill_next = r_fill;
    end else begin
      w_fill_next = r_fill + LEN_W'(1);
    end
    if (cfg_len > LEN_MAX) begin
      w_len_clamped = LEN_MAX;
    end else begin
      w_len_clamped = cfg_len;
    end
    w_mask  = len_mask(32'(r_len));
    w_diff  = (MAX_PAT_W'(w_hist_next) ^ MAX_PAT_W'(r_pat)) & w_mask;
    w_match = w_accept && (r_len != '0) && (w_fill_next >= r_len) && (w_diff == '0);
  end

  // Non-overlapping mode empties the fill count on a match so the next one needs fresh bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat   <= DEF_PAT;
      r_len   <= LEN_W'(DEF_LEN);
      r_ovl   <= DEF_OVL;
      r_hist  <= '0;
      r_fill  <= '0;
      r_found <= 1'b0;
    end else if (cfg_load) begin
      r_pat   <= cfg_pattern;
      r_len   <= w_len_clamped;
      r_ovl   <= cfg_overlap;
      r_hist  <= '0;
      r_fill  <= '0;
      r_found <= 1'b0;
    end else if (w_accept) begin
      r_hist  <= w_hist_next;
      r_fill  <= (w_match && !r_ovl) ? '0 : w_fill_next;
      r_found <= w_match;
    end else begin
      r_found <= 1'b0;
    end
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_match),
    .i_clr (cnt_clr),
    .o_cnt (match_cnt),
    .o_sat (cnt_sat)
  );

  assign seq_found = r_found;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default and a 2-bit-counter instance share stimulus.
module tb_seq_detector_param;

  localparam int PAT_W = 16;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             data_in = 1'b0;
  logic             data_valid = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             seq_found, cnt_sat, seq_found2, cnt_sat2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .seq_found(seq_found), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .seq_found(seq_found2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic b, input logic v);
    data_in    = b;
    data_valid = v;
    @(posedge clk);
    #1;
    if (seq_found) pulses++;
  endtask

  task automatic send_seq(input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], 1'b1);
      if (i != 0) repeat (gap) send(1'b1, 1'b0);
    end
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl, input logic dv, input logic din);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    send(din, dv);
    cfg_load    = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_found", 32'(seq_found), 32'd0);
    check_eq("rst_cnt", 32'(match_cnt), 32'd0);
    check_eq("rst_sat", 32'(cnt_sat), 32'd0);
    rst = 1'b1;

    // T1 default pattern 110100
    pulses = 0;
    send_seq(16'b110100, 6, 0);
    check_eq("t1_pulse", 32'(seq_found), 32'd1);
    send(1'b0, 1'b0);
    check_eq("t1_width", 32'(seq_found), 32'd0);
    check_eq("t1_pulses", 32'(pulses), 32'd1);
    check_eq("t1_cnt", 32'(match_cnt), 32'd1);

    // T2 overlap vs non-overlap
    load(16'b110, 5'd3, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    send_seq(16'b110110, 6, 0);
    send(1'b0, 1'b0);
    check_eq("t2_ovl_pulses", 32'(pulses), 32'd2);
    check_eq("t2_ovl_cnt", 32'(match_cnt), 32'd3);
    load(16'b110, 5'd3, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    send_seq(16'b110110, 6, 0);
    send(1'b0, 1'b0);
    check_eq("t2_novl_pulses", 32'(pulses), 32'd2);
    load(16'b101, 5'd3, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    send_seq(16'b10101, 5, 0);
    send(1'b0, 1'b0);
    check_eq("t2_101_novl", 32'(pulses), 32'd1);
    load(16'b101, 5'd3, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    send_seq(16'b10101, 5, 0);
    send(1'b0, 1'b0);
    check_eq("t2_101_ovl", 32'(pulses), 32'd2);
    check_eq("t2_cnt", 32'(match_cnt), 32'd8);

    // T3 gaps of three idle cycles between bits
    load(16'b110100, 5'd6, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    send_seq(16'b110100, 6, 3);
    check_eq("t3_pulse", 32'(seq_found), 32'd1);
    repeat (3) send(1'b1, 1'b0);
    check_eq("t3_pulses", 32'(pulses), 32'd1);
    check_eq("t3_cnt", 32'(match_cnt), 32'd9);

    // T4 reload mid-stream discards history and the load-cycle bit
    pulses = 0;
    send_seq(16'b110, 3, 0);
    load(16'b110100, 5'd6, 1'b1, 1'b1, 1'b1);
    check_eq("t4_load_found", 32'(seq_found), 32'd0);
    send_seq(16'b100, 3, 0);
    send(1'b0, 1'b0);
    check_eq("t4_no_match", 32'(pulses), 32'd0);
    send_seq(16'b110100, 6, 0);
    check_eq("t4_pulse", 32'(seq_found), 32'd1);
    check_eq("t4_cnt", 32'(match_cnt), 32'd10);

    // T5 saturation on the 2-bit counter and clear-vs-match priority
    cnt_clr = 1'b1;
    send(1'b0, 1'b0);
    cnt_clr = 1'b0;
    check_eq("t5_clr_cnt", 32'(match_cnt), 32'd0);
    load(16'b11, 5'd2, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    repeat (6) send(1'b1, 1'b1);
    check_eq("t5_pulses", 32'(pulses), 32'd5);
    check_eq("t5_cnt", 32'(match_cnt), 32'd5);
    check_eq("t5_sat_cnt", 32'(match_cnt2), 32'd3);
    check_eq("t5_sat_flag", 32'(cnt_sat2), 32'd1);
    cnt_clr = 1'b1;
    send(1'b1, 1'b1);
    cnt_clr = 1'b0;
    check_eq("t5_clr_found", 32'(seq_found2), 32'd1);
    check_eq("t5_clr_sat_cnt", 32'(match_cnt2), 32'd0);
    check_eq("t5_clr_sat_flag", 32'(cnt_sat2), 32'd0);
    check_eq("t5_clr_cnt2", 32'(match_cnt), 32'd0);
    send(1'b1, 1'b1);
    check_eq("t5_after_clr", 32'(match_cnt2), 32'd1);
    send(1'b0, 1'b0);

    // T6 limits: len 0, full length, clamped length, async reset
    load(16'hFFFF, 5'd0, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 64; i++) send(1'($urandom_range(1, 0)), 1'b1);
    check_eq("t6_len0", 32'(pulses), 32'd0);
    load(16'hFFFF, 5'd16, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    repeat (15) send(1'b1, 1'b1);
    check_eq("t6_full_early", 32'(pulses), 32'd0);
    send(1'b1, 1'b1);
    check_eq("t6_full_pulse", 32'(seq_found), 32'd1);
    load(16'hFFFF, 5'd31, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    repeat (15) send(1'b1, 1'b1);
    check_eq("t6_clamp_early", 32'(pulses), 32'd0);
    send(1'b1, 1'b1);
    check_eq("t6_clamp_pulse", 32'(seq_found), 32'd1);
    send(1'b1, 1'b1);
    check_eq("t6_pre_rst_cnt", 32'(match_cnt), 32'd4);
    #3;
    rst = 1'b0;
    #1;
    check_eq("t6_async_found", 32'(seq_found), 32'd0);
    check_eq("t6_async_cnt", 32'(match_cnt), 32'd0);
    check_eq("t6_async_sat", 32'(cnt_sat2), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pulses = 0;
    send_seq(16'b100, 3, 0);
    send_seq(16'b110100, 6, 0);
    check_eq("t6_default_back", 32'(seq_found), 32'd1);
    check_eq("t6_post_pulses", 32'(pulses), 32'd1);
    check_eq("t6_post_cnt", 32'(match_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
